// File: rtl/mnist_input_frame_packer_if.sv
// Valid/ready stream bundle used for both the pixel input and the packed frame output.
interface mnist_input_frame_packer_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/mnist_input_frame_packer.sv
// Binarizes a pixel stream and packs NUM_PIXELS bits per frame (pixel 0 = LSB),
// double-buffered so a full frame can wait for the consumer while the next one fills.
module mnist_input_frame_packer #(
    parameter int NUM_PIXELS = 784,
    parameter int PIX_W      = 8,
    parameter int THRESH     = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    mnist_input_frame_packer_if.slave         pix_i,
    mnist_input_frame_packer_if.master        frm_o,
    output logic                              frame_err_o
);
    localparam int CNT_W = $clog2(NUM_PIXELS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {FILL, HOLD, DISCARD} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_PIXELS-1:0]   fill_q;
    logic [NUM_PIXELS-1:0]   m_data_q;
    logic                    m_valid_q;
    logic                    resync_q;
    logic                    frame_err_q;

    logic                    beat;
    logic                    slot_free;
    logic                    pix_bit;
    logic [NUM_PIXELS-1:0]   fill_done;

    // s_ready depends on state only, keeping m_ready off any path to s_ready.
    assign pix_i.ready = (state_q != HOLD);
    assign beat        = pix_i.valid & pix_i.ready;
    assign slot_free   = !m_valid_q | frm_o.ready;
    assign pix_bit     = (pix_i.data >= PIX_W'(THRESH));

    always_comb begin
        fill_done                 = fill_q;
        fill_done[NUM_PIXELS-1]   = pix_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            resync_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (m_valid_q && frm_o.ready)
                m_valid_q <= 1'b0;

            case (state_q)
                FILL: begin
                    if (beat) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_q       <= '0;
                            frame_err_q <= !pix_i.last;
                            if (slot_free) begin
                                m_data_q  <= fill_done;
                                m_valid_q <= 1'b1;
                                fill_q    <= '0;
                                state_q   <= pix_i.last ? FILL : DISCARD;
                            end else begin
                                fill_q   <= fill_done;
                                resync_q <= !pix_i.last;
                                state_q  <= HOLD;
                            end
                        end else if (pix_i.last) begin
                            // Short frame: drop the partial vector entirely.
                            cnt_q       <= '0;
                            fill_q      <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            fill_q[cnt_q] <= pix_bit;
                            cnt_q         <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        m_data_q  <= fill_q;
                        m_valid_q <= 1'b1;
                        fill_q    <= '0;
                        resync_q  <= 1'b0;
                        state_q   <= resync_q ? DISCARD : FILL;
                    end
                end
                DISCARD: begin
                    if (beat && pix_i.last) begin
                        cnt_q   <= '0;
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign frm_o.valid = m_valid_q;
    assign frm_o.data  = m_data_q;
    assign frm_o.last  = 1'b1;
    assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_mnist_input_frame_packer.sv
// Randomized bench for the frame packer against a frame-level queue model.
module tb_mnist_input_frame_packer;
    localparam int NP = 784;
    localparam int PW = 8;
    localparam int TH = 128;

    logic clk = 1'b0;
    logic rst;
    logic frame_err;

    mnist_input_frame_packer_if #(.DATA_W(PW)) pix ();
    mnist_input_frame_packer_if #(.DATA_W(NP)) frm ();

    mnist_input_frame_packer #(.NUM_PIXELS(NP), .PIX_W(PW), .THRESH(TH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_i       (pix),
        .frm_o       (frm),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_err = 0;
    int obs_err = 0;
    int rdy_mode = 1;          // 0: hold low, 1: hold high, 2: random
    logic [NP-1:0] expq[$];
    bit cur[$];
    bit discarding = 0;
    logic [NP-1:0] prev_data;
    bit prev_hold = 0;
    logic [NP-1:0] alt_vec;

    task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: collect bits, emit at NP, resync on long/short frames.
    task automatic model_beat(input logic [PW-1:0] d, input logic l);
        logic [NP-1:0] v;
        if (discarding) begin
            if (l) discarding = 0;
        end else begin
            cur.push_back(d >= TH);
            if (cur.size() == NP) begin
                for (int k = 0; k < NP; k++) v[k] = cur[k];
                expq.push_back(v);
                cur.delete();
                if (!l) begin
                    discarding = 1;
                    exp_err++;
                end
            end else if (l) begin
                cur.delete();
                exp_err++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [PW-1:0] d, input logic l, output bit acc);
        @(negedge clk);
        cyc++;
        if (cyc > 90000) begin
            $display("FAIL timeout cycles=%0d", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
            $fatal(1);
        end
        if (frame_err) obs_err++;
        if (prev_hold) chk("hold_stable", frm.data, prev_data);
        case (rdy_mode)
            0:       frm.ready = 1'b0;
            1:       frm.ready = 1'b1;
            default: frm.ready = 1'($urandom_range(0, 1));
        endcase
        pix.valid = v;
        pix.data  = d;
        pix.last  = l;
        acc = v && pix.ready;
        if (frm.valid && frm.ready) begin
            chk("out_avail", NP'(expq.size() > 0), NP'(1));
            if (expq.size() > 0) chk("frame", frm.data, expq.pop_front());
        end
        prev_hold = frm.valid && !frm.ready;
        prev_data = frm.data;
        if (acc) model_beat(d, l);
    endtask

    task automatic send_pix(input logic [PW-1:0] d, input logic l);
        bit acc;
        do begin
            if ($urandom_range(0, 9) == 0) step(1'b0, PW'($urandom), 1'b0, acc);
            step(1'b1, d, l, acc);
        end while (!acc);
    endtask

    // mode 0: 0/255 alternating, 1: 127/128 alternating, 2: all 255, 3: random
    task automatic send_frame(input int n, input int mode, input bit give_last);
        logic [PW-1:0] d;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       d = k[0] ? 8'd255 : 8'd0;
                1:       d = k[0] ? 8'd128 : 8'd127;
                2:       d = 8'd255;
                default: d = PW'($urandom);
            endcase
            send_pix(d, give_last && (k == n - 1));
        end
    endtask

    task automatic drain();
        bit acc;
        rdy_mode = 1;
        for (int i = 0; i < 3000 && expq.size() != 0; i++) step(1'b0, '0, 1'b0, acc);
        repeat (3) step(1'b0, '0, 1'b0, acc);
        chk("drain_empty", NP'(expq.size()), NP'(0));
        chk("err_count", NP'(obs_err), NP'(exp_err));
    endtask

    task automatic peek_frame(input string tag, input logic [NP-1:0] exp);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, NP'(frm.valid), NP'(1));
        chk(tag, frm.data, exp);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        pix.valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_mvalid"}, NP'(frm.valid), NP'(0));
        chk({tag, "_mdata"}, frm.data, '0);
        chk({tag, "_sready"}, NP'(pix.ready), NP'(1));
        cur.delete();
        expq.delete();
        discarding = 0;
        prev_hold = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int n;
        for (int k = 0; k < NP; k++) alt_vec[k] = k[0];
        rst = 1'b1;
        pix.valid = 1'b0;
        pix.data = '0;
        pix.last = 1'b0;
        frm.ready = 1'b1;
        #13;
        chk("rst_mvalid", NP'(frm.valid), NP'(0));
        chk("rst_ferr", NP'(frame_err), NP'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sready", NP'(pix.ready), NP'(1));
        chk("rst_mdata", frm.data, '0);

        // Basic alternating frame with one-cycle output pulse
        rdy_mode = 1;
        send_frame(NP, 0, 1);
        peek_frame("basic", alt_vec);
        step(1'b0, '0, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("basic_one_cycle", NP'(frm.valid), NP'(0));

        // Threshold boundary and all-ones
        send_frame(NP, 1, 1);
        peek_frame("thresh", alt_vec);
        send_frame(NP, 2, 1);
        peek_frame("ones", '1);
        drain();

        // Backpressure: second frame parks in HOLD
        rdy_mode = 0;
        send_frame(NP, 3, 1);
        send_frame(NP, 3, 1);
        @(posedge clk);
        #1;
        chk("bp_sready", NP'(pix.ready), NP'(0));
        chk("bp_mvalid", NP'(frm.valid), NP'(1));
        chk("bp_front", frm.data, expq[0]);
        rdy_mode = 1;
        step(1'b0, '0, 1'b0, acc);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_mvalid2", NP'(frm.valid), NP'(1));
        chk("bp_sready2", NP'(pix.ready), NP'(1));
        chk("bp_second", frm.data, expq[0]);
        drain();

        // Short frame then clean frame
        rdy_mode = 2;
        send_frame(100, 3, 1);
        send_frame(NP, 3, 1);
        drain();

        // Long frame then aligned frame
        rdy_mode = 2;
        send_frame(800, 3, 1);
        send_frame(NP, 3, 1);
        drain();

        // Reset mid-frame and while a frame is held
        rdy_mode = 1;
        send_frame(400, 3, 0);
        do_reset("rst_mid");
        rdy_mode = 0;
        send_frame(NP, 3, 1);
        @(posedge clk);
        #1;
        chk("pre_rst_vld", NP'(frm.valid), NP'(1));
        do_reset("rst_held");
        rdy_mode = 2;
        send_frame(NP, 0, 1);
        drain();

        // Random lengths and backpressure
        for (int f = 0; f < 6; f++) begin
            rdy_mode = $urandom_range(1, 2);
            case ($urandom_range(0, 9))
                0:       n = $urandom_range(1, NP - 1);
                1:       n = $urandom_range(NP + 1, NP + 40);
                default: n = NP;
            endcase
            send_frame(n, 3, 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mnist_input_frame_packer.md
Name: mnist_input_frame_packer

Overview:
- Upstream feeder for ensemble layer 0: accepts a grayscale MNIST pixel stream, one pixel per beat.
- Thresholds each pixel to 1 bit and packs NUM_PIXELS bits into one frame vector.
- Presents the complete vector, with a valid/ready handshake, to the layer-0 neuron LUT bank, which taps its 8-bit fan-in slices from it.
- Two-deep buffering (fill register plus output register) sustains 1 pixel/cycle across back-to-back frames.

Parameters:
NUM_PIXELS, 784, pixels per frame; also the width of m_data.
PIX_W, 8, input pixel width.
THRESH, 128, binarization threshold; bit = 1 iff pixel >= THRESH (unsigned compare).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  pixel beat valid.
s_ready  out  1  packer can accept a pixel.
s_data  in  PIX_W  unsigned pixel value.
s_last  in  1  marks the final pixel of a frame.
m_valid  out  1  frame vector valid.
m_ready  in  1  layer 0 accepts the frame.
m_data  out  NUM_PIXELS  packed binarized frame; bit k = pixel k of the frame, so pixel 0 is the LSB.
frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Transfers: input beat = s_valid & s_ready; output transfer = m_valid & m_ready.
- Reset (async assert, sync release):
  - state=FILL, pixel count=0, fill register=0.
  - m_valid=0, m_data=0, frame_err=0, so s_ready=1 immediately after release.
- Counter width: ceil(log2(NUM_PIXELS)).
- Output slot free ("slot_free") = !m_valid | m_ready, evaluated in the same cycle.
- State FILL:
  - On each input beat, write bit count of the fill register = (s_data >= THRESH).
  - Beat with count < NUM_PIXELS-1 and s_last=0: count++.
  - Beat with count < NUM_PIXELS-1 and s_last=1 (short frame): discard the partial frame, count=0, clear the fill register, pulse frame_err next cycle, stay in FILL.
  - Beat with count == NUM_PIXELS-1 (frame complete, including this pixel): count=0.
    - If s_last=0: pulse frame_err and go to DISCARD after the frame completion below.
    - If slot_free: load the completed vector into m_data, set m_valid=1 next cycle, clear the fill register.
    - Otherwise go to HOLD, keeping the fill register.
  - Simultaneous frame-complete beat and output transfer: load the new frame in the same edge; m_valid stays 1 with no bubble.
- State HOLD:
  - s_ready=0.
  - When slot_free: load m_data from the fill register, m_valid=1, clear the fill register.
  - Then go to FILL, or to DISCARD if the pending resync flag is set.
- State DISCARD (long frame, resync):
  - s_ready=1; beats are consumed and ignored.
  - On a beat with s_last=1, go to FILL with count=0.
  - A completed frame waiting here for an output slot is still handled as in HOLD: DISCARD has priority only over input bits.
  - Simplification: a long-frame error whose output slot is blocked goes HOLD -> DISCARD.
- s_ready = (state != HOLD), combinational from state only; there is no combinational path from m_ready to s_ready.
- Output side:
  - m_data and m_valid are registered and held stable while m_valid & !m_ready.
  - m_valid clears on an output transfer unless a new frame loads in the same edge.
- Latency: last pixel accepted at edge t -> m_valid=1 after edge t, provided slot_free at t.
- Throughput: 1 pixel/cycle sustained when m_ready is held high.
- frame_err: single-cycle registered pulse; never asserted during or right after reset.
- Reset mid-frame or mid-HOLD drops all partial and pending data; no partial frame is ever emitted.

Test Plan:
- Basic frame: 784 beats, pixels alternating 0/255, s_last on beat 783, m_ready=1 -> m_valid for exactly 1 cycle after the last beat; m_data = 0xAAAA...A (odd bits set); frame_err never pulses.
- Threshold boundary: pixels 127 at even k and 128 at odd k -> same alternating vector. All-255 frame -> m_data all ones.
- Backpressure: two back-to-back frames with m_ready=0 -> frame 1 held on m_data, frame 2 fills then HOLD, s_ready=0. Raise m_ready for 1 cycle -> frame 2 loads in the same edge, m_valid stays 1, s_ready returns to 1. Frames arrive in order and unchanged.
- Short frame: s_last on beat 99 -> frame_err pulse, no m_valid. The next full 784-beat frame is emitted correctly with no stale bits.
- Long frame: 800 beats with s_last on beat 799 -> first 784 pixels emitted with a frame_err pulse; beats 784..799 dropped. The next frame is aligned.
- Async reset asserted mid-frame (beat 400) and again while m_valid=1 -> m_valid=0, m_data=0, s_ready=1 with no clock edge needed. The following frame is clean.
